// File: rtl/rc6_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc6_sched_pkg
// Description : Shared types and constants for the RC6 block sequencer:
//               FSM state encoding, block width and default core timing.
// Revision    : 1.0 - initial release
// ============================================================================
package rc6_sched_pkg;

  // RC6-32/20 operates on fixed 128-bit blocks.
  localparam int c_blk_w    = 128;
  // Cycles from core din strobe to core done strobe.
  localparam int c_core_lat = 19;
  // Watchdog limit in cycles after the din strobe.
  localparam int c_tmo      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rc6_cbc_chain.sv
`default_nettype none
// ============================================================================
// Module      : rc6_cbc_chain
// Description : ECB/CBC chaining for the RC6 block sequencer. Holds the
//               chaining value and the saved ciphertext for CBC decrypt,
//               and provides the pre-core and post-core XOR muxes.
// Ports       : i_clk, i_rst_n     - clock, async active-low reset
//               i_cbc, i_enc       - frame mode (latched by the parent)
//               i_load_iv, i_iv    - load IV into the chain at frame start
//               i_in_acc, i_in_data- accepted input block
//               i_cap, i_dout      - captured core result
//               o_pre              - block to present to the core
//               o_post             - block to present on the output stream
// Revision    : 1.0 - initial release
// ============================================================================
module rc6_cbc_chain
  import rc6_sched_pkg::*;
#(
  parameter int BLK_W = c_blk_w
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cbc,
  input  logic             i_enc,
  input  logic             i_load_iv,
  input  logic [BLK_W-1:0] i_iv,
  input  logic             i_in_acc,
  input  logic [BLK_W-1:0] i_in_data,
  input  logic             i_cap,
  input  logic [BLK_W-1:0] i_dout,
  output logic [BLK_W-1:0] o_pre,
  output logic [BLK_W-1:0] o_post
);

  logic [BLK_W-1:0] r_chain;
  logic [BLK_W-1:0] r_prev;
  logic             w_cbc_enc;
  logic             w_cbc_dec;

  assign w_cbc_enc = i_cbc & i_enc;
  assign w_cbc_dec = i_cbc & ~i_enc;

  // Encrypt whitens the plaintext before the core; decrypt unwhitens after.
  assign o_pre  = w_cbc_enc ? (i_in_data ^ r_chain) : i_in_data;
  assign o_post = w_cbc_dec ? (i_dout ^ r_chain) : i_dout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
      r_prev  <= '0;
    end else begin
      // IV load (IDLE) and result capture (RUN) are mutually exclusive.
      if (i_load_iv) begin
        r_chain <= i_iv;
      end else if (i_cap) begin
        // Next chaining value is always the ciphertext of this block:
        // the core output when encrypting, the saved input when decrypting.
        r_chain <= i_enc ? i_dout : r_prev;
      end
      if (i_in_acc && w_cbc_dec) begin
        r_prev <= i_in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc6_blk_sched.sv
`default_nettype none
// ============================================================================
// Module      : rc6_blk_sched
// Description : Block sequencer for the iterative RC6 round datapath.
//               Accepts a frame of blocks on a valid/ready stream, issues
//               them one at a time to the core, applies ECB/CBC chaining,
//               and returns results on an output valid/ready stream.
//               A watchdog aborts the frame if the core never answers.
// Ports       : i_clk, i_rst_n                 - clock, async active-low reset
//               i_start/i_enc/i_cbc/i_iv/i_blk_cnt - frame setup (IDLE only)
//               i_abort                        - synchronous abort
//               i_s_data/i_s_valid/o_s_ready   - input block stream
//               o_m_data/o_m_valid/i_m_ready   - output block stream
//               o_core_din/o_core_din_en/o_core_flag - core request
//               i_core_dout/i_core_dout_en     - core response
//               o_busy, o_done, o_err          - status
// Revision    : 1.0 - initial release
// ============================================================================
module rc6_blk_sched
  import rc6_sched_pkg::*;
#(
  parameter int BLK_W    = c_blk_w,
  parameter int CORE_LAT = c_core_lat,
  parameter int TMO      = c_tmo,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_enc,
  input  logic             i_cbc,
  input  logic [BLK_W-1:0] i_iv,
  input  logic [CNT_W-1:0] i_blk_cnt,
  input  logic             i_abort,
  input  logic [BLK_W-1:0] i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic [BLK_W-1:0] o_m_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [BLK_W-1:0] o_core_din,
  output logic             o_core_din_en,
  output logic             o_core_flag,
  input  logic [BLK_W-1:0] i_core_dout,
  input  logic             i_core_dout_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  // A watchdog shorter than the core latency would kill every block.
  localparam int c_tmo_eff = (TMO > CORE_LAT) ? TMO : CORE_LAT + 1;
  localparam int c_tmr_w   = $clog2(c_tmo_eff);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_tmo_eff - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_enc;
  logic               r_cbc;
  logic [CNT_W-1:0]   r_rem;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_s_ready;
  logic               r_m_valid;
  logic               r_din_en;
  logic               r_done;
  logic               r_err;
  logic [BLK_W-1:0]   r_core_din;
  logic [BLK_W-1:0]   r_m_data;

  logic               w_s_ready_nxt;
  logic               w_m_valid_nxt;
  logic               w_din_en_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_start;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_cap;
  logic               w_tmo;
  logic [BLK_W-1:0]   w_pre;
  logic [BLK_W-1:0]   w_post;

  assign w_start  = (r_state == ST_IDLE) & i_start & ~i_abort;
  assign w_in_hs  = r_s_ready & i_s_valid;
  assign w_out_hs = r_m_valid & i_m_ready;
  assign w_cap    = (r_state == ST_RUN) & i_core_dout_en & ~i_abort;
  assign w_tmo    = (r_state == ST_RUN) & ~i_core_dout_en & ~i_abort
                    & (r_timer == c_tmr_last);

  rc6_cbc_chain #(
    .BLK_W (BLK_W)
  ) u_chain (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_cbc     (r_cbc),
    .i_enc     (r_enc),
    .i_load_iv (w_start),
    .i_iv      (i_iv),
    .i_in_acc  (w_in_hs),
    .i_in_data (i_s_data),
    .i_cap     (w_cap),
    .i_dout    (i_core_dout),
    .o_pre     (w_pre),
    .o_post    (w_post)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_s_ready_nxt = 1'b0;
    w_din_en_nxt  = 1'b0;
    w_m_valid_nxt = r_m_valid;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_blk_cnt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // Ready rises one cycle after entering LOAD and drops on handshake.
        if (w_in_hs) begin
          w_din_en_nxt = 1'b1;
          w_state_nxt  = ST_ISSUE;
        end else begin
          w_s_ready_nxt = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_core_dout_en) begin
          w_m_valid_nxt = 1'b1;
          w_state_nxt   = ST_OUT;
        end else if (r_timer == c_tmr_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (w_out_hs) begin
          w_m_valid_nxt = 1'b0;
          if (r_rem == CNT_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      w_state_nxt   = ST_IDLE;
      w_s_ready_nxt = 1'b0;
      w_din_en_nxt  = 1'b0;
      w_m_valid_nxt = 1'b0;
      w_done_nxt    = 1'b0;
    end
  end

  // Sticky error: cleared by a new frame, set by timeout or by a core done
  // strobe that arrives when nothing is outstanding.
  always_comb begin
    w_err_nxt = r_err;
    if (w_start) begin
      w_err_nxt = 1'b0;
    end
    if (w_tmo || (i_core_dout_en && (r_state != ST_RUN))) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_enc      <= 1'b0;
      r_cbc      <= 1'b0;
      r_rem      <= '0;
      r_timer    <= '0;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_din_en   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_core_din <= '0;
      r_m_data   <= '0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_din_en  <= w_din_en_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      if (w_start) begin
        r_enc <= i_enc;
        r_cbc <= i_cbc;
        r_rem <= i_blk_cnt;
      end
      if (w_in_hs) begin
        r_core_din <= w_pre;
      end
      if (r_state == ST_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == ST_RUN) begin
        r_timer <= r_timer + c_tmr_w'(1);
      end
      if (w_cap) begin
        r_m_data <= w_post;
      end
      if (w_out_hs && !i_abort && (r_rem != '0)) begin
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  assign o_s_ready     = r_s_ready;
  assign o_m_data      = r_m_data;
  assign o_m_valid     = r_m_valid;
  assign o_core_din    = r_core_din;
  assign o_core_din_en = r_din_en;
  assign o_core_flag   = r_enc;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rc6_blk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc6_blk_sched
// Description : Self-checking bench for rc6_blk_sched with a stub core
//               (encrypt = bitwise NOT, decrypt = 64-bit half swap) and a
//               frame-level ECB/CBC reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc6_blk_sched;

  localparam int c_lat = 19;
  localparam int c_tmo = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, enc, cbc, abort;
  logic [127:0] iv;
  logic [15:0]  blk_cnt;
  logic [127:0] s_data;
  logic         s_valid, s_ready;
  logic [127:0] m_data;
  logic         m_valid, m_ready;
  logic [127:0] core_din;
  logic         core_din_en, core_flag;
  logic [127:0] core_dout;
  logic         core_dout_en;
  logic         busy, done, err;

  rc6_blk_sched dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_enc          (enc),
    .i_cbc          (cbc),
    .i_iv           (iv),
    .i_blk_cnt      (blk_cnt),
    .i_abort        (abort),
    .i_s_data       (s_data),
    .i_s_valid      (s_valid),
    .o_s_ready      (s_ready),
    .o_m_data       (m_data),
    .o_m_valid      (m_valid),
    .i_m_ready      (m_ready),
    .o_core_din     (core_din),
    .o_core_din_en  (core_din_en),
    .o_core_flag    (core_flag),
    .i_core_dout    (core_dout),
    .i_core_dout_en (core_dout_en),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  logic [127:0] exp_din_q[$];
  logic [127:0] exp_out_q[$];
  logic [127:0] got_din_q[$];
  logic [127:0] got_out_q[$];
  logic [127:0] blk[8];
  logic         cur_enc     = 1'b0;
  bit           stub_on     = 1'b1;
  bit           chk_spacing = 1'b0;
  int           ready_mode  = 1;
  int           last_din_cyc   = -1;
  int           last_hs_cyc    = -1;
  int           last_in_hs_cyc = -1;
  int           done_cyc       = -1;
  int           done_cnt       = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stub core transform; differs per direction so a wrong flag is visible.
  function automatic logic [127:0] core_f(input logic [127:0] x, input logic e);
    return e ? ~x : {x[63:0], x[127:64]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-side ready driver: 0 random, 1 always ready, 2 stalled.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = ($urandom_range(0, 3) != 0);
      1:       m_ready = 1'b1;
      default: m_ready = 1'b0;
    endcase
  end

  // Stub core: answers each din strobe exactly c_lat cycles later.
  initial begin
    logic [127:0] d;
    logic         f;
    core_dout_en = 1'b0;
    core_dout    = '0;
    forever begin
      @(negedge clk);
      if (core_din_en && stub_on) begin
        d = core_din;
        f = core_flag;
        repeat (c_lat) @(posedge clk);
        #1;
        core_dout    = core_f(d, f);
        core_dout_en = 1'b1;
        @(posedge clk);
        #1;
        core_dout_en = 1'b0;
        core_dout    = rnd128();
      end
    end
  end

  // Compare process: checks DUT against the model on every meaningful cycle.
  initial begin
    logic prev_mvalid;
    prev_mvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (core_din_en) begin
        got_din_q.push_back(core_din);
        if (exp_din_q.size() == 0) fail_now("core_din_unexpected", "strobe with no block pending");
        else check("core_din", core_din, exp_din_q.pop_front());
        check("core_flag", core_flag, cur_enc);
        if (chk_spacing) begin
          if (last_din_cyc >= 0) check("din_spacing", cyc - last_din_cyc, 23);
          check("hs_to_din", cyc - last_in_hs_cyc, 1);
        end
        last_din_cyc = cyc;
      end
      if (m_valid && !prev_mvalid && chk_spacing)
        check("hs_to_mvalid", cyc - last_in_hs_cyc, 21);
      if (m_valid && m_ready) begin
        got_out_q.push_back(m_data);
        if (exp_out_q.size() == 0) fail_now("m_data_unexpected", "output with no result pending");
        else check("m_data", m_data, exp_out_q.pop_front());
        last_hs_cyc = cyc;
      end
      if (s_ready && core_din_en) fail_now("ready_during_strobe", "s_ready=1 with din_en=1, required 0");
      if (busy) check("flag_busy", core_flag, cur_enc);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_mvalid = m_valid;
    end
  end

  task automatic feed(input logic [127:0] d, input bit gap);
    int t;
    if (gap) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    s_data  = d;
    s_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready && t < 300);
    if (!s_ready) fail_now("s_ready_timeout", "no input handshake within 300 cycles");
    else last_in_hs_cyc = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = rnd128();
  endtask

  task automatic pulse_start(input logic e, input logic c, input logic [127:0] v, input int n);
    @(posedge clk);
    #1;
    start = 1'b1; enc = e; cbc = c; iv = v; blk_cnt = n[15:0];
    @(posedge clk);
    #1;
    // Scramble setup inputs to prove they are latched on start.
    start = 1'b0; enc = $urandom; cbc = $urandom; iv = rnd128(); blk_cnt = $urandom;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int t;
    t = 0;
    while (done_cnt == d0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) fail_now("done_timeout", "no o_done within cycle budget");
  endtask

  // Runs one frame over blk[0..n-1]; expectations come from ECB/CBC rules.
  task automatic run_frame(input logic e, input logic c, input logic [127:0] v,
                           input int n, input bit gap);
    logic [127:0] chain, cin, cout;
    int d0;
    chain = v;
    for (int k = 0; k < n; k++) begin
      if (e) begin
        cin   = c ? (blk[k] ^ chain) : blk[k];
        cout  = core_f(cin, 1'b1);
        exp_out_q.push_back(cout);
        chain = cout;
      end else begin
        cin   = blk[k];
        cout  = core_f(cin, 1'b0);
        exp_out_q.push_back(c ? (cout ^ chain) : cout);
        chain = blk[k];
      end
      exp_din_q.push_back(cin);
    end
    cur_enc      = e;
    last_din_cyc = -1;
    d0           = done_cnt;
    pulse_start(e, c, v, n);
    for (int k = 0; k < n; k++) feed(blk[k], gap);
    wait_done(d0, 3000);
    check("done_after_last_hs", done_cyc, last_hs_cyc + 1);
    check("out_q_drained", exp_out_q.size(), 0);
    check("din_q_drained", exp_din_q.size(), 0);
    @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("busy_after_frame", busy, 1'b0);
    check("err_after_frame", err, 1'b0);
  endtask

  initial begin
    int  d0;
    int  t;
    bit  ok;
    logic [127:0] hold;
    rst_n = 1'b0; start = 1'b0; enc = 1'b0; cbc = 1'b0; iv = '0; blk_cnt = '0;
    abort = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    #2;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_din_en", core_din_en, 0);
    check("rst_flag", core_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m_data", m_data, 0);
    check("rst_core_din", core_din, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ECB encrypt 1,2,3: timing and literal results.
    ready_mode = 1; chk_spacing = 1'b1;
    blk[0] = 128'd1; blk[1] = 128'd2; blk[2] = 128'd3;
    got_out_q.delete(); got_din_q.delete();
    run_frame(1'b1, 1'b0, rnd128(), 3, 1'b0);
    chk_spacing = 1'b0;
    check("ecb_out_count", got_out_q.size(), 3);
    check("ecb_lit0", got_out_q[0], ~128'd1);
    check("ecb_lit1", got_out_q[1], ~128'd2);
    check("ecb_lit2", got_out_q[2], ~128'd3);

    // CBC encrypt, all-ones IV, two zero blocks.
    blk[0] = '0; blk[1] = '0;
    got_out_q.delete(); got_din_q.delete();
    run_frame(1'b1, 1'b1, {128{1'b1}}, 2, 1'b0);
    check("cbc_din0", got_din_q[0], {128{1'b1}});
    check("cbc_din1", got_din_q[1], 128'd0);
    check("cbc_out0", got_out_q[0], 128'd0);
    check("cbc_out1", got_out_q[1], {128{1'b1}});

    // Randomised frames, all modes, random gaps and backpressure.
    ready_mode = 0;
    for (int f = 0; f < 10; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) blk[k] = rnd128();
      run_frame(1'($urandom), 1'($urandom), rnd128(), n, 1'b1);
    end

    // Long backpressure in OUT.
    ready_mode = 2;
    blk[0] = rnd128(); blk[1] = rnd128();
    fork
      run_frame(1'b0, 1'b1, rnd128(), 2, 1'b0);
      begin
        t = 0;
        while (!m_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        hold = m_data;
        ok = m_valid;
        repeat (50) begin
          @(negedge clk);
          if (m_data !== hold || s_ready || core_din_en || !m_valid) ok = 1'b0;
        end
        check("bp_hold", ok, 1'b1);
        ready_mode = 1;
      end
    join

    // Watchdog: core never answers.
    stub_on = 1'b0;
    cur_enc = 1'b1;
    blk[0] = rnd128();
    exp_din_q.push_back(blk[0]);
    last_din_cyc = -1;
    d0 = done_cnt;
    pulse_start(1'b1, 1'b0, '0, 1);
    feed(blk[0], 1'b0);
    wait_done(d0, 200);
    check("tmo_done_cycle", done_cyc, last_din_cyc + c_tmo + 1);
    check("tmo_err", err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_m_valid", m_valid, 1'b0);
    stub_on = 1'b1;

    // Zero-length frame: done next cycle, clears the sticky error.
    d0 = done_cnt;
    pulse_start(1'b0, 1'b0, '0, 0);
    cur_enc = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_err_cleared", err, 1'b0);
    check("zero_busy", busy, 1'b0);
    check("zero_s_ready", s_ready, 1'b0);
    @(negedge clk);
    check("zero_done_pulse", done_cnt - d0, 1);

    // Abort during RUN, then a late core strobe.
    cur_enc = 1'b1;
    blk[0] = rnd128();
    exp_din_q.push_back(blk[0]);
    d0 = done_cnt;
    pulse_start(1'b1, 1'b0, '0, 2);
    feed(blk[0], 1'b0);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_din_en", core_din_en, 1'b0);
    check("abort_err_kept", err, 1'b0);
    repeat (25) @(negedge clk);
    check("abort_late_err", err, 1'b1);
    check("abort_no_done", done_cnt - d0, 0);
    exp_out_q.delete(); exp_din_q.delete();

    // Reset mid-frame.
    cur_enc = 1'b0;
    blk[0] = rnd128();
    exp_din_q.push_back(blk[0]);
    pulse_start(1'b0, 1'b1, rnd128(), 3);
    feed(blk[0], 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_flag", core_flag, 1'b0);
    check("mid_rst_outs", {s_ready, m_valid, core_din_en, done, err}, 5'b0);
    check("mid_rst_core_din", core_din, 0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_out_q.delete(); exp_din_q.delete();
    @(negedge clk);
    check("post_rst_err", err, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // One more clean frame after reset.
    ready_mode = 0;
    for (int k = 0; k < 3; k++) blk[k] = rnd128();
    run_frame(1'b0, 1'b1, rnd128(), 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL global_timeout: bench did not finish within 5 ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/rc6_blk_sched.md
Name: rc6_blk_sched

Overview:
- Block sequencer for the iterative RC6 round datapath used in the image encryption path.
- Takes a frame of N 128-bit image blocks on a valid/ready stream and issues one block at a time to the core: one-cycle din strobe, then waits for the core's done strobe.
- Captures each result and presents it on an output valid/ready stream.
- Adds ECB/CBC chaining, holds the core direction flag stable per frame, and runs a timeout watchdog on the core.

Parameters:
- BLK_W, 128, block width; fixed for RC6-32/20.
- CORE_LAT, 19, cycles from core din strobe to core done strobe.
- TMO, 32, watchdog limit in cycles after the din strobe; must be greater than CORE_LAT.
- CNT_W, 16, width of the frame block counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame start pulse; accepted only in IDLE.
- i_enc  in  1  1 = encrypt, 0 = decrypt; latched on start.
- i_cbc  in  1  1 = CBC, 0 = ECB; latched on start.
- i_iv  in  128  CBC IV; latched on start.
- i_blk_cnt  in  CNT_W  blocks in the frame; latched on start.
- i_abort  in  1  synchronous abort.
- i_s_data  in  128  input block.
- i_s_valid  in  1  input valid.
- o_s_ready  out  1  input ready.
- o_m_data  out  128  output block.
- o_m_valid  out  1  output valid.
- i_m_ready  in  1  output ready.
- o_core_din  out  128  core data in.
- o_core_din_en  out  1  core start strobe, one cycle.
- o_core_flag  out  1  core direction (1 = encrypt).
- i_core_dout  in  128  core result; valid only while i_core_dout_en is high.
- i_core_dout_en  in  1  core done strobe.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle pulse at frame end.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (async, i_rst_n low):
  - FSM to IDLE.
  - All outputs 0: o_s_ready, o_m_valid, o_core_din_en, o_core_flag, o_busy, o_done, o_err.
  - o_m_data, o_core_din, chain register and counters all 0.
- FSM states: IDLE, LOAD, ISSUE, RUN, OUT.
- IDLE:
  - On i_start, latch enc, cbc, iv (into chain) and blk_cnt (into rem); clear o_err.
  - If blk_cnt = 0: pulse o_done next cycle and stay in IDLE. Otherwise go to LOAD.
- LOAD:
  - o_s_ready = 1, registered and asserted only in this state.
  - On handshake: r_core_din = cbc&enc ? data^chain : data. If cbc&!enc, save the input to r_prev. Go to ISSUE.
- ISSUE:
  - o_core_din_en = 1 for exactly this cycle, with o_core_din = r_core_din.
  - Load timer = 0. Go to RUN.
- RUN:
  - Timer increments every cycle.
  - On i_core_dout_en: o_m_data = cbc&!enc ? dout^chain : dout.
  - Chain update: enc → dout; dec → r_prev.
  - o_m_valid = 1 from the next cycle. Go to OUT.
  - If timer reaches TMO with no strobe: set o_err, pulse o_done, go to IDLE.
- OUT:
  - Hold o_m_data and o_m_valid until i_m_ready.
  - On handshake: rem -= 1, drop o_m_valid. If rem reaches 0, pulse o_done and go to IDLE; else go to LOAD.
- Latency: input handshake to o_m_valid = 1 (ISSUE) + CORE_LAT + 1 = 21 cycles at CORE_LAT = 19.
- Throughput with zero backpressure: one block per 23 cycles.
- o_core_flag is the latched enc bit. It is constant from start to frame end and never changes while the core is busy.
- Core strobes:
  - o_core_din_en is never re-asserted before the core's done strobe or a timeout; a re-strobe would restart the core.
  - i_core_dout_en outside RUN is ignored but sets o_err. Data is not captured.
- i_abort: in any state, go to IDLE next cycle. Clear o_m_valid, o_s_ready and o_core_din_en. No o_done pulse; o_err is unchanged.
- i_start outside IDLE is ignored.
- Reset mid-frame: immediate return to reset values. The core's internal state is then don't-care; the next frame's din strobe restarts it.
- Arithmetic: rem decrements mod 2^CNT_W but is never decremented below 1; XORs are full 128-bit.

Decomposition:
- Package rc6_sched_pkg holds:
  - the state enum (IDLE/LOAD/ISSUE/RUN/OUT);
  - the default CORE_LAT and TMO values;
  - the BLK_W constant.
- Sub-module rc6_cbc_chain holds the chain register, r_prev, the pre-XOR and post-XOR muxes, and the load-IV/update controls.

Test Plan:
- ECB encrypt, stub core (dout = ~din after 19 cycles), blk_cnt = 3, inputs 0x0…01/02/03 → outputs ~0x01, ~0x02, ~0x03 in order. One o_core_din_en per block, 23-cycle spacing, o_done once after the third output handshake.
- CBC encrypt, iv = 0xFF…FF, stub core, blk_cnt = 2, inputs 0x0 and 0x0 → core sees 0xFF…FF then 0x0 (= ~0xFF…FF ^ 0). Outputs 0x0…0 then 0xFF…FF. o_core_flag = 1 throughout.
- Integration with the real RC6 core, key all zero, ECB encrypt of 0x0…0 → 8fc3a53656b1f778c129df4e9848a41e. Decrypting that frame returns 0x0…0, with o_core_flag = 0 throughout.
- Backpressure: hold i_m_ready = 0 for 50 cycles in OUT → o_m_data stable, o_s_ready = 0, no din strobe. Release → next LOAD.
- Stub never returns done → o_err = 1 and o_done pulses at timer = TMO (32), FSM in IDLE. The next i_start clears o_err.
- i_start with blk_cnt = 0 → o_done the next cycle, no handshakes. i_abort in RUN → IDLE next cycle, no o_done, a late i_core_dout_en sets o_err. i_rst_n low mid-frame → all outputs 0.
